// File: rtl/nes_palette_lookup.sv
// nes_palette_lookup: NES PPU per-pixel palette lookup with credit-checked FIFO.
// Optional grayscale masking via NES_PAL_GRAYSCALE_EN.
module nes_palette_lookup #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       px_valid,
  output logic       px_ready,
  input  logic [1:0] px_color,
  input  logic [1:0] px_pal,
  input  logic       px_sprite,
  input  logic       px_eol,
  input  logic       gray,
  output logic [4:0] pal_addr,
  input  logic [7:0] pal_dout,
  output logic       col_valid,
  input  logic       col_ready,
  output logic [5:0] col_idx,
  output logic       col_transp,
  output logic       col_eol,
  output logic       err_range
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef NES_PAL_GRAYSCALE_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  logic          r_s1_valid;
  logic          r_s1_transp;
  logic          r_s1_eol;
  logic          r_s2_valid;
  logic          r_s2_transp;
  logic          r_s2_eol;
  logic [4:0]    r_pal_addr;
  logic          r_err;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [EW-1:0] r_mem [DEPTH];

  logic          w_acc;
  logic [4:0]    w_addr;
  logic [CW:0]   w_sum;
  logic          w_wr;
  logic          w_rd;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_head;
  logic [5:0]    w_head_idx;
  logic [5:0]    w_idx;

`ifdef NES_PAL_GRAYSCALE_EN
  logic          r_s1_gray;
  logic          r_s2_gray;
`else
  logic          w_unused_gray;
  assign w_unused_gray = gray;
`endif

  // Transparent pixels collapse onto the universal backdrop entry.
  assign w_addr = (px_color == 2'd0) ? 5'h00
                : {px_sprite, px_pal, px_color};

  // Credits: buffered plus in-flight entries must stay below DEPTH.
  assign w_sum = (CW+1)'(r_count)
               + (CW+1)'(r_s1_valid)
               + (CW+1)'(r_s2_valid);
  assign px_ready = rst_n & (w_sum < (CW+1)'(DEPTH));
  assign w_acc = px_valid & px_ready;

  assign w_wr = r_s2_valid;
  assign w_rd = col_valid & col_ready;

`ifdef NES_PAL_GRAYSCALE_EN
  assign w_wdata = {pal_dout[5:0], r_s2_transp, r_s2_eol, r_s2_gray};
`else
  assign w_wdata = {pal_dout[5:0], r_s2_transp, r_s2_eol};
`endif

  // S1: address register and meta capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_transp <= 1'b0;
      r_s1_eol    <= 1'b0;
      r_pal_addr  <= 5'h00;
`ifdef NES_PAL_GRAYSCALE_EN
      r_s1_gray   <= 1'b0;
`endif
    end else begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_pal_addr  <= w_addr;
        r_s1_transp <= (px_color == 2'd0);
        r_s1_eol    <= px_eol;
`ifdef NES_PAL_GRAYSCALE_EN
        r_s1_gray   <= gray;
`endif
      end
    end
  end

  // S2: meta follows the ROM read, no stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_transp <= 1'b0;
      r_s2_eol    <= 1'b0;
`ifdef NES_PAL_GRAYSCALE_EN
      r_s2_gray   <= 1'b0;
`endif
    end else begin
      r_s2_valid  <= r_s1_valid;
      r_s2_transp <= r_s1_transp;
      r_s2_eol    <= r_s1_eol;
`ifdef NES_PAL_GRAYSCALE_EN
      r_s2_gray   <= r_s1_gray;
`endif
    end
  end

  // Sticky flag for ROM bytes outside the 6-bit colour range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_s2_valid && (pal_dout[7:6] != 2'b00)) begin
      r_err <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_idx = w_head[EW-1 -: 6];

`ifdef NES_PAL_GRAYSCALE_EN
  assign w_idx = w_head[0] ? (w_head_idx & 6'h30) : w_head_idx;
`else
  assign w_idx = w_head_idx;
`endif

  assign col_valid  = (r_count != '0);
  assign col_idx    = col_valid ? w_idx : 6'h00;
  assign col_transp = col_valid & w_head[EW-7];
  assign col_eol    = col_valid & w_head[EW-8];
  assign pal_addr   = r_pal_addr;
  assign err_range  = r_err;

endmodule

// File: tb/tb_nes_palette_lookup.sv
// tb_nes_palette_lookup: scoreboard bench for nes_palette_lookup.
// Behavioural ROM plus reference model of the palette rules.
module tb_nes_palette_lookup;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       px_valid, px_ready;
  logic [1:0] px_color, px_pal;
  logic       px_sprite, px_eol, gray;
  logic [4:0] pal_addr;
  logic [7:0] pal_dout;
  logic       col_valid, col_ready;
  logic [5:0] col_idx;
  logic       col_transp, col_eol, err_range;

  logic [7:0] rom [32];
  logic [7:0] q [$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [5:0] last_idx;

  nes_palette_lookup #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_color(px_color), .px_pal(px_pal),
    .px_sprite(px_sprite), .px_eol(px_eol), .gray(gray),
    .pal_addr(pal_addr), .pal_dout(pal_dout),
    .col_valid(col_valid), .col_ready(col_ready),
    .col_idx(col_idx), .col_transp(col_transp),
    .col_eol(col_eol), .err_range(err_range)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pal_dout <= rom[pal_addr];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference: palette address rules, ROM lookup, optional gray mask.
  function automatic logic [7:0] model(logic [1:0] c, logic [1:0] p,
                                       logic s, logic e, logic g);
    int a;
    int idx;
    a = (c == 0) ? 0 : (s * 16 + p * 4 + c);
    idx = rom[a] % 64;
`ifdef NES_PAL_GRAYSCALE_EN
    if (g) idx = (idx / 16) * 16;
`else
    if (g) idx = idx;
`endif
    return {idx[5:0], (c == 0), e};
  endfunction

  // Stimulus side: each accept pushes its expected response.
  always @(negedge clk)
    if (rst_n && px_valid && px_ready)
      q.push_back(model(px_color, px_pal, px_sprite, px_eol, gray));

  // Output side: every pop is compared with the queue head.
  always @(negedge clk)
    if (rst_n && col_valid && col_ready) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        chk("col_out", {col_idx, col_transp, col_eol}, q.pop_front());
        last_idx = col_idx;
      end
    end

  task automatic drv(bit v, bit [1:0] c, bit [1:0] p, bit s, bit e, bit g);
    @(posedge clk); #1;
    px_valid = v; px_color = c; px_pal = p;
    px_sprite = s; px_eol = e; gray = g;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_px(bit v);
    drv(v, 2'($urandom), 2'($urandom), 1'($urandom),
        1'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || col_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", (t >= 100), 0);
  endtask

  initial begin
    int acc;
    int stall;
    logic [4:0] pat;
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom_range(0, 63));
    rom[5'h00] = 8'h0F; rom[5'h01] = 8'h15; rom[5'h0A] = 8'h36;
    rom[5'h17] = 8'h24; rom[5'h1B] = 8'h37;
    rst_n = 1'b0; col_ready = 1'b1;
    px_valid = 0; px_color = 0; px_pal = 0;
    px_sprite = 0; px_eol = 0; gray = 0;
    #1;
    chk("rst_px_ready", px_ready, 0);
    chk("rst_col", {col_valid, col_idx, col_transp, col_eol}, 0);
    chk("rst_addr_err", {pal_addr, err_range}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", px_ready, 1);

    // 1: latency of a single pixel.
    drv(1, 1, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    chk("lat_addr", pal_addr, 5'h01);
    chk("lat_n0", col_valid, 0);
    @(negedge clk);
    chk("lat_n1", col_valid, 0);
    @(negedge clk);
    chk("lat_n2", {col_valid, col_idx, col_transp}, {1'b1, 6'h15, 1'b0});
    drain();

    // 2: universal backdrop.
    drv(1, 0, 3, 1, 0, 0);
    idle();
    @(negedge clk);
    chk("bd_addr", pal_addr, 5'h00);
    drain();
    chk("bd_idx", last_idx, 6'h0F);

    // 3: streaming three pixels back to back.
    drv(1, 2, 2, 0, 0, 0);
    @(negedge clk); chk("st_ready0", px_ready, 1);
    drv(1, 3, 1, 1, 0, 0);
    @(negedge clk); chk("st_ready1", px_ready, 1);
    drv(1, 3, 2, 1, 1, 0);
    @(negedge clk); chk("st_ready2", px_ready, 1);
    idle();
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat = {pat[3:0], col_valid};
    end
    chk("st_consec", pat, 5'b11100);
    drain();

    // 4: backpressure fills exactly DEPTH entries.
    col_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      rnd_px(1);
      @(negedge clk);
      if (px_ready) acc++;
    end
    chk("bp_accepts", acc, 4);
    chk("bp_ready_low", px_ready, 0);
    stall = 0;
    for (int i = 0; i < 12; i++) begin
      rnd_px(1);
      col_ready = 1'b1;
      @(negedge clk);
      if (i >= 3 && !px_ready) stall++;
    end
    chk("bp_resume", stall, 0);
    idle();
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rnd_px(($urandom_range(0, 9) < 7));
      col_ready = ($urandom_range(0, 9) < 6);
    end
    idle();
    col_ready = 1'b1;
    drain();

    // 5: grayscale and range error.
    drv(1, 3, 1, 1, 0, 1);
    idle();
    drain();
`ifdef NES_PAL_GRAYSCALE_EN
    chk("gray_idx", last_idx, 6'h20);
`else
    chk("gray_idx", last_idx, 6'h24);
`endif
    chk("err_clear", err_range, 0);
    rom[5'h05] = 8'hC5;
    drv(1, 1, 1, 0, 0, 0);
    idle();
    drain();
    chk("err_set", err_range, 1);
    repeat (5) idle();
    chk("err_sticky", err_range, 1);

    // 6: reset with three entries buffered.
    col_ready = 1'b0;
    drv(1, 1, 0, 0, 0, 0);
    drv(1, 2, 2, 0, 0, 0);
    drv(1, 3, 1, 1, 0, 0);
    idle();
    repeat (3) idle();
    chk("pre_rst_valid", col_valid, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst", {col_valid, err_range, px_ready}, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    col_ready = 1'b1;
    drv(1, 2, 2, 0, 0, 0);
    idle();
    @(negedge clk);
    chk("post_rst_n0", col_valid, 0);
    @(negedge clk);
    chk("post_rst_n1", col_valid, 0);
    @(negedge clk);
    chk("post_rst_n2", {col_valid, col_idx}, {1'b1, 6'h36});
    drain();
    chk("q_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nes_palette_lookup.md
# nes_palette_lookup

Per-pixel palette lookup stage of the NES PPU rendering pipeline. It accepts background/sprite pixels (2-bit colour, 2-bit palette select, sprite flag) from the pixel composer and forms the 5-bit palette-memory address, applying the universal-backdrop rule. It drives the 32-entry palette ROM (1-cycle registered read), realigns the returned byte with its pixel, and buffers the resulting 6-bit NES system-colour index for the RGB/VGA encoder downstream. Valid/ready handshakes sit on both sides, backed by a credit-checked output FIFO.

## Interface
- DEPTH, 4, output FIFO entries; power of two, 4..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- px_valid  in  1  input pixel valid.
- px_ready  out  1  input accept; transfer on px_valid & px_ready.
- px_color  in  2  pattern colour bits; 0 = transparent.
- px_pal  in  2  palette select (attribute / sprite attribute).
- px_sprite  in  1  1 = sprite palettes (0x10–0x1F), 0 = background palettes.
- px_eol  in  1  last pixel of scanline; passed through.
- gray  in  1  PPUMASK grayscale bit, sampled on accept.
- pal_addr  out  5  address to palette ROM.
- pal_dout  in  8  ROM data, valid one clk after pal_addr is sampled.
- col_valid  out  1  output colour valid.
- col_ready  in  1  downstream accept.
- col_idx  out  6  NES system colour index.
- col_transp  out  1  source px_color was 0.
- col_eol  out  1  passthrough of px_eol.
- err_range  out  1  sticky: a ROM byte had bits [7:6] ≠ 0.

## Operation
- Address: px_color == 0 → pal_addr = 5'h00. Otherwise pal_addr = {px_sprite, px_pal, px_color}.
- S1 (address register): loads pal_addr plus meta (transp, eol, gray) on accept; s1_valid = accepted.
- S2: meta moves S1→S2 every cycle unconditionally. The ROM samples pal_addr at that same edge.
- Write: when s2_valid, {pal_dout[5:0], transp, eol, gray} is written into the FIFO.
- The pipeline never stalls internally. Backpressure is handled by credits only:
  - px_ready = rst_n & (fifo_count + s1_valid + s2_valid < DEPTH).
  - No pop credit is taken in the same cycle.
- Output: the FIFO is show-ahead.
  - col_valid = fifo not empty.
  - col_idx / col_transp / col_eol come from the head entry.
  - A pop occurs on col_valid & col_ready.
- err_range is set when s2_valid & (pal_dout[7:6] ≠ 0). It is cleared only by reset.
- pal_addr holds its last value when S1 is idle.

## Timing
- Reset values (asynchronous):
  - s1_valid, s2_valid, fifo_count, err_range = 0.
  - pal_addr = 0.
  - col_valid = 0; col_idx = 0; col_transp = 0; col_eol = 0.
  - px_ready = 0 while rst_n is low, and 1 on the first cycle after release.
- Latency: accept at edge N → S1 at N → ROM registers at N+1 → FIFO write at N+2. col_valid is high after edge N+2 (2 cycles) when the FIFO was empty.
- Throughput: 1 pixel/clk with col_ready held high and DEPTH ≥ 4.
- Full: the credit sum reaching DEPTH drops px_ready. In-flight entries always have FIFO room, so no overflow and no pixel loss.
- Simultaneous FIFO write and pop: count unchanged, including at count = DEPTH-1 and count = 1. Empty with write only: data is visible the next cycle, with no bypass.
- FIFO pointers wrap modulo DEPTH.
- Reset mid-operation: all in-flight and buffered pixels are discarded, with no partial output.

## Configuration
- NES_PAL_GRAYSCALE_EN defined:
  - col_idx = gray_entry ? (idx & 6'h30) : idx.
  - The masking is applied at the FIFO output.
- NES_PAL_GRAYSCALE_EN undefined:
  - The gray port exists but is ignored.
  - The gray meta bit is not stored.
  - col_idx = raw ROM bits [5:0].

## Test plan
The bench ROM model has 1-cycle latency. It holds entries 0x00=0x0F, 0x01=0x15, 0x0A=0x36, 0x17=0x24, 0x1B=0x37.

1. Latency: single pixel, color=1, pal=0, sprite=0, accepted at edge N, col_ready=1 → pal_addr=0x01, col_valid after N+2, col_idx=0x15, col_transp=0.
2. Backdrop: color=0, pal=3, sprite=1 → pal_addr=0x00, col_idx=0x0F, col_transp=1.
3. Streaming: back-to-back pixels mapping to addresses 0x0A, 0x17, 0x1B with eol on the last, col_ready=1 → outputs 0x36, 0x24, 0x37 on consecutive cycles; col_eol set only on the third; px_ready never drops.
4. Backpressure: col_ready=0 with a continuous input stream, DEPTH=4 → exactly 4 accepts, then px_ready=0. Raise col_ready → all 4 pop in order, no loss or duplication, and 1/clk throughput resumes.
5. Grayscale with macro defined: gray=1, addr 0x17 → col_idx=0x20. Without the macro the same stimulus gives 0x24. A ROM byte of 0xC5 sets err_range=1, which stays set until reset.
6. Reset mid-stream: rst_n low with 3 entries buffered → col_valid=0 and err_range=0 immediately. After release, the first new pixel returns with 2-cycle latency.
